spi_xfer_queue: RTL

//   Buffered command front-end sitting directly upstream of spi_master.

---
 rtl/spi_xfer_queue.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_queue.sv
// Small first-word-fall-through FIFO with explicit occupancy count.
// Latency: one cycle from push to head visible.
// Backpressure: o_full blocks further pushes, and a pop when empty is ignored.
module spi_xq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// Queued SPI command front-end: CMD FIFO -> one transfer at a time on spi_master -> RSP FIFO.
// Latency: a command accepted in cycle 0 with the queue empty is requested on the SPI side in cycle 2.
// Backpressure: cmd_ready drops when the CMD FIFO is full; no issue while the RSP FIFO has no free slot.
module spi_xfer_queue #(
    parameter int CMD_DEPTH    = 4,
    parameter int RSP_DEPTH    = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_data,
    input  logic [5:0]  i_cmd_nbits,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic [31:0] o_spi_mosi_data,
    output logic [5:0]  o_spi_nbits,
    output logic        o_spi_request,
    input  logic [31:0] i_spi_miso_data,
    input  logic        i_spi_ready,
    output logic        o_busy
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  nbits;
    } cmd_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_mosi;
    logic [5:0]  r_nbits;
    logic [TW-1:0] r_tmo;

    cmd_t        w_cmd_in;
    cmd_t        w_cmd_head;
    logic        w_cmd_push;
    logic        w_cmd_pop;
    logic        w_cmd_full;
    logic        w_cmd_empty;
    rsp_t        w_rsp_in;
    rsp_t        w_rsp_head;
    logic        w_rsp_push;
    logic        w_rsp_pop;
    logic        w_rsp_full;
    logic        w_rsp_empty;
    logic        w_nbits_bad;
    logic        w_latch;
    logic        w_tmo_clr;
    logic        w_tmo_inc;
    logic [31:0] w_mask;

    assign w_cmd_in    = '{data: i_cmd_data, nbits: i_cmd_nbits};
    assign w_cmd_push  = i_cmd_valid && o_cmd_ready;
    assign w_rsp_pop   = o_rsp_valid && i_rsp_ready;
    assign w_nbits_bad = (w_cmd_head.nbits == 6'd0) || (w_cmd_head.nbits > 6'd32);
    // r_nbits is 1..32 whenever the mask is used, so the shift is 0..31.
    assign w_mask      = 32'hFFFF_FFFF >> (6'd32 - r_nbits);

    spi_xq_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_cmd_push),
        .i_push_dat (w_cmd_in),
        .i_pop      (w_cmd_pop),
        .o_head_dat (w_cmd_head),
        .o_full     (w_cmd_full),
        .o_empty    (w_cmd_empty)
    );

    spi_xq_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_rsp_push),
        .i_push_dat (w_rsp_in),
        .i_pop      (w_rsp_pop),
        .o_head_dat (w_rsp_head),
        .o_full     (w_rsp_full),
        .o_empty    (w_rsp_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_pop     = 1'b0;
        w_rsp_push    = 1'b0;
        w_rsp_in      = '{err: 1'b0, data: 32'd0};
        w_latch       = 1'b0;
        w_tmo_clr     = 1'b0;
        w_tmo_inc     = 1'b0;
        o_spi_request = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only one transfer is ever in flight, and it exists only outside IDLE,
                // so a non-full RSP FIFO here guarantees room for its result.
                if ((!w_cmd_empty || w_cmd_push) && !w_rsp_full) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_cmd_pop = 1'b1;
                if (w_nbits_bad) begin
                    w_rsp_push  = 1'b1;
                    w_rsp_in    = '{err: 1'b1, data: 32'd0};
                    w_state_nxt = S_IDLE;
                end else begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_spi_ready && !i_reset) begin
                    o_spi_request = 1'b1;
                    w_tmo_clr     = 1'b1;
                    w_state_nxt   = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!i_spi_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_tmo == TW'(BUSY_TIMEOUT)) begin
                    w_rsp_push  = 1'b1;
                    w_rsp_in    = '{err: 1'b1, data: 32'd0};
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (i_spi_ready) begin
                    w_rsp_push  = 1'b1;
                    w_rsp_in    = '{err: 1'b0, data: i_spi_miso_data & w_mask};
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mosi  <= '0;
            r_nbits <= '0;
            r_tmo   <= '0;
        end else begin
            if (w_latch) begin
                r_mosi  <= w_cmd_head.data;
                r_nbits <= w_cmd_head.nbits;
            end
            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign o_cmd_ready     = !w_cmd_full;
    assign o_rsp_valid     = !w_rsp_empty;
    assign o_rsp_data      = w_rsp_head.data;
    assign o_rsp_err       = w_rsp_head.err;
    assign o_spi_mosi_data = r_mosi;
    assign o_spi_nbits     = r_nbits;
    assign o_busy          = !w_cmd_empty || !w_rsp_empty || (r_state != S_IDLE);
endmodule
